flash_line_cache: RTL and testbench
===================================

# flash_line_cache

Direct-mapped, read-only line cache that sits directly upstream of the TileLink SPI flash controller. It accepts single-beat TL-UL requests from the CPU/crossbar side. Hits are served from local storage. On a miss, it issues one 16-byte burst Get to the flash controller and refills a whole line from its 4-beat AccessAckData response. This removes the multi-microsecond SPI command overhead for sequential instruction fetch.

## Interface
Parameters:
- TL_RS, 3: TileLink source-ID width, both sides.
- LINES, 8: number of cache lines; power of two, 2..64.

Ports:
- flash_clock_i  in  1  single clock; all logic is posedge.
- flash_reset_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  one-cycle pulse; invalidates all lines.
- cpu_a_opcode  in  3  TL A opcode.
- cpu_a_size  in  4  log2 bytes.
- cpu_a_source  in  TL_RS  requester ID.
- cpu_a_address  in  24  byte address.
- cpu_a_valid  in  1  A channel valid.
- cpu_a_ready  out  1  A channel ready.
- cpu_d_opcode  out  3  D channel opcode.
- cpu_d_size  out  4  echoes the request size.
- cpu_d_source  out  TL_RS  echoes the request source.
- cpu_d_denied  out  1  D channel denied.
- cpu_d_data  out  32  D channel data.
- cpu_d_corrupt  out  1  D channel corrupt.
- cpu_d_valid  out  1  D channel valid.
- cpu_d_ready  in  1  D channel ready.
- mem_a_size  out  4  always 4, i.e. 16 bytes.
- mem_a_source  out  TL_RS  always 0.
- mem_a_address  out  24  line base address; bits [3:0] are 0.
- mem_a_valid  out  1  request to the flash controller.
- mem_a_ready  in  1  flash controller ready.
- mem_d_opcode, mem_d_size, mem_d_source, mem_d_denied, mem_d_data[31:0], mem_d_corrupt, mem_d_valid  in  flash controller response channel.
- mem_d_ready  out  1  response ready toward the flash controller.

## Operation
- Address split:
  - offset = addr[3:0]; word = addr[3:2].
  - index = addr[4 +: log2(LINES)].
  - tag = addr[23 : 4+log2(LINES)].
- Per line: a valid bit, a tag, and 4 × 32-bit words.
- FSM states are IDLE, LOOKUP, REQ, FILL, RESP.
- IDLE:
  - cpu_a_ready = 1, and only in this state.
  - On A fire, latch opcode, size, source and address; go to LOOKUP.
- LOOKUP:
  - Opcode ≠ Get(4), or size > 2: prepare the response and go to RESP. The response is:
    - d_denied = 1.
    - opcode = AccessAck(0) for Put, AccessAckData(1) for any other opcode.
    - data = 0.
  - Hit (valid & tag match): d_data = line word, opcode 1, denied 0, corrupt 0; go to RESP.
  - Miss: go to REQ.
- REQ:
  - mem_a_valid = 1, held stable until mem_a_ready.
  - On fire, clear the beat counter and the error flag; go to FILL.
- FILL:
  - mem_d_ready = 1.
  - On each mem_d fire, write beat k (bytes base+4k..base+4k+3) into word k of the line.
  - If k == word, capture the beat as the response data.
  - OR mem_d_denied | mem_d_corrupt into the error flag.
  - On beat 3:
    - Set valid and tag only if the error flag is clear and no flush occurred during the fill.
    - Response: opcode 1, denied = error, corrupt = error.
    - Go to RESP.
- RESP:
  - cpu_d_valid = 1, with all D fields held stable until cpu_d_ready.
  - On fire, go to IDLE.
- flush_i clears all valid bits in any state, the same cycle.
  - A flush coinciding with a hit in LOOKUP still returns the hit data.
  - A flush during FILL blocks validation of that line; the fill still completes and still responds.
- Sub-word Get (size 0/1) returns the full aligned 32-bit word. The requester selects the bytes.

## Timing
- Reset (asynchronous assert, synchronous deassert externally):
  - State is IDLE; all valid bits are 0; beat counter is 0.
  - All outputs are 0 except mem_a_size = 4.
  - The flash controller must share this reset. An in-flight fill is abandoned.
- Hit: A fire at edge 0, LOOKUP during cycle 1, cpu_d_valid high from cycle 2.
- Deny: same latency as a hit, with no mem_a traffic.
- Miss: mem_a_valid high from cycle 2. cpu_d_valid rises the cycle after the beat-3 fire.
- Throughput: one outstanding request. The cpu_a_ready to response path is not combinational.
- mem_d beats arriving while not in FILL are an integration error. Such beats are ignored and must be flagged by a bench assertion.

## Structure
- flash_cache_pkg holds:
  - state enum.
  - TL opcode constants: GET = 4, PUT_FULL = 0, PUT_PARTIAL = 1, ACCESS_ACK = 0, ACCESS_ACK_DATA = 1.
  - LINE_BYTES = 16, BEATS = 4, FILL_SIZE = 4.
- One sub-module, flash_cache_array:
  - tag/valid/data storage with a combinational read port.
  - a word-write port.
  - a line-validate port.
  - a flush-all port.

## Test plan
- Cold Get, addr 0x000104, size 2 → mem_a address 0x000100, size 4. Beats 11111111, 22222222, 33333333, 44444444 → cpu_d_data 0x22222222, opcode 1.
- Repeat Get to 0x00010C → no mem_a_valid; cpu_d_valid at cycle 2 with data 0x44444444.
- Conflict: Get 0x000180 with LINES = 8 (same index, different tag) → refill. A subsequent Get to 0x000100 misses again.
- PutFull (opcode 0) to 0x000000 → AccessAck, denied 1, no flash access. Get size 3 → AccessAckData, denied 1.
- Fill where beat 2 has mem_d_corrupt = 1 → cpu_d_corrupt = 1 and denied = 1; the next access to that line misses.
- flush_i during FILL beat 1, and cpu_d_ready held low for 5 cycles in RESP → response stable throughout; the line is not valid afterwards.
- Reset asserted mid-FILL → all outputs 0 immediately and the cache is empty.

Source files
------------

// File: rtl/flash_cache_pkg.sv
// Shared types and constants for the flash line cache: FSM states, TileLink
// opcodes and line geometry.
package flash_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_FILL,
        S_RESP
    } state_e;

    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    localparam int         ADDR_W     = 24;
    localparam int         LINE_BYTES = 16;
    localparam int         BEATS      = 4;
    localparam int         OFFSET_W   = $clog2(LINE_BYTES);
    localparam int         WORD_W     = $clog2(BEATS);
    localparam logic [3:0] FILL_SIZE  = 4'd4;

    // Puts get a data-less ack; everything else unsupported gets AccessAckData.
    function automatic logic [2:0] deny_opcode(input logic [2:0] op);
        return (op == PUT_FULL || op == PUT_PARTIAL) ? ACCESS_ACK : ACCESS_ACK_DATA;
    endfunction

endpackage

// File: rtl/flash_cache_array.sv
// Direct-mapped tag/valid/data storage: combinational lookup, per-word write,
// per-line validate and a global flush.
module flash_cache_array
    import flash_cache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = ADDR_W - OFFSET_W - IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    input  logic [WORD_W-1:0] rd_word_i,
    output logic              rd_hit_o,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_word_i,
    input  logic [31:0]       wr_data_i,
    input  logic              val_en_i,
    input  logic [IDX_W-1:0]  val_idx_i,
    input  logic [TAG_W-1:0]  val_tag_i,
    input  logic              val_set_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][BEATS];

    assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i][rd_word_i];

    // Flush wins over a same-cycle validate so a flushed fill never lands valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (val_en_i) begin
            valid_q[val_idx_i] <= val_set_i;
        end
    end

    // NOTE: tags and data are guarded by valid_q, so they need no reset;
    // leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        end
        if (val_en_i) begin
            tag_q[val_idx_i] <= val_tag_i;
        end
    end

endmodule

// File: rtl/flash_line_cache.sv
// Read-only direct-mapped line cache in front of the SPI flash controller:
// hits served locally, misses refilled with one 16-byte TL-UL burst Get.
module flash_line_cache
    import flash_cache_pkg::*;
#(
    parameter int TL_RS = 3,
    parameter int LINES = 8
) (
    input  logic             flash_clock_i,
    input  logic             flash_reset_ni,
    input  logic             flush_i,
    input  logic [2:0]       cpu_a_opcode,
    input  logic [3:0]       cpu_a_size,
    input  logic [TL_RS-1:0] cpu_a_source,
    input  logic [23:0]      cpu_a_address,
    input  logic             cpu_a_valid,
    output logic             cpu_a_ready,
    output logic [2:0]       cpu_d_opcode,
    output logic [3:0]       cpu_d_size,
    output logic [TL_RS-1:0] cpu_d_source,
    output logic             cpu_d_denied,
    output logic [31:0]      cpu_d_data,
    output logic             cpu_d_corrupt,
    output logic             cpu_d_valid,
    input  logic             cpu_d_ready,
    output logic [3:0]       mem_a_size,
    output logic [TL_RS-1:0] mem_a_source,
    output logic [23:0]      mem_a_address,
    output logic             mem_a_valid,
    input  logic             mem_a_ready,
    input  logic [2:0]       mem_d_opcode,
    input  logic [3:0]       mem_d_size,
    input  logic [TL_RS-1:0] mem_d_source,
    input  logic             mem_d_denied,
    input  logic [31:0]      mem_d_data,
    input  logic             mem_d_corrupt,
    input  logic             mem_d_valid,
    output logic             mem_d_ready
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

    state_e            state_q;
    logic              a_ready_q, d_valid_q, mem_a_valid_q, mem_d_ready_q;
    logic [2:0]        req_op_q;
    logic [3:0]        req_size_q;
    logic [TL_RS-1:0]  req_src_q;
    logic [23:0]       req_addr_q;
    logic [2:0]        d_opcode_q;
    logic              d_denied_q, d_corrupt_q;
    logic [31:0]       d_data_q;
    logic [WORD_W-1:0] beat_q;
    logic              err_q, flush_seen_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic              a_fire, mem_a_fire, mem_d_fire, d_fire, last_beat;
    logic              req_deny, fill_err_d, line_hit;
    logic [31:0]       line_word;
    logic              unused_inputs;

    assign req_idx    = req_addr_q[OFFSET_W +: IDX_W];
    assign req_tag    = req_addr_q[ADDR_W-1 : OFFSET_W+IDX_W];
    assign req_word   = req_addr_q[OFFSET_W-1 -: WORD_W];
    assign a_fire     = cpu_a_valid && a_ready_q;
    assign mem_a_fire = mem_a_valid_q && mem_a_ready;
    assign mem_d_fire = (state_q == S_FILL) && mem_d_valid && mem_d_ready_q;
    assign d_fire     = d_valid_q && cpu_d_ready;
    assign last_beat  = mem_d_fire && (beat_q == WORD_W'(BEATS - 1));
    assign fill_err_d = err_q || mem_d_denied || mem_d_corrupt;
    assign req_deny   = (req_op_q != GET) || (req_size_q > 4'd2);

    // Response side-band fields of the flash controller carry nothing we use.
    assign unused_inputs = ^{mem_d_opcode, mem_d_size, mem_d_source, req_addr_q[1:0]};

    flash_cache_array #(.LINES(LINES)) u_array (
        .clk_i     (flash_clock_i),
        .rst_ni    (flash_reset_ni),
        .flush_i   (flush_i),
        .rd_idx_i  (req_idx),
        .rd_tag_i  (req_tag),
        .rd_word_i (req_word),
        .rd_hit_o  (line_hit),
        .rd_data_o (line_word),
        .wr_en_i   (mem_d_fire),
        .wr_idx_i  (req_idx),
        .wr_word_i (beat_q),
        .wr_data_i (mem_d_data),
        .val_en_i  (last_beat),
        .val_idx_i (req_idx),
        .val_tag_i (req_tag),
        .val_set_i (!fill_err_d && !flush_seen_q && !flush_i)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // a blocking '=' would leak a new value into later reads in this block.
    always_ff @(posedge flash_clock_i or negedge flash_reset_ni) begin
        if (!flash_reset_ni) begin
            state_q       <= S_IDLE;
            a_ready_q     <= 1'b0;
            d_valid_q     <= 1'b0;
            mem_a_valid_q <= 1'b0;
            mem_d_ready_q <= 1'b0;
            req_op_q      <= '0;
            req_size_q    <= '0;
            req_src_q     <= '0;
            req_addr_q    <= '0;
            d_opcode_q    <= '0;
            d_denied_q    <= 1'b0;
            d_corrupt_q   <= 1'b0;
            d_data_q      <= '0;
            beat_q        <= '0;
            err_q         <= 1'b0;
            flush_seen_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_fire) begin
                        req_op_q   <= cpu_a_opcode;
                        req_size_q <= cpu_a_size;
                        req_src_q  <= cpu_a_source;
                        req_addr_q <= cpu_a_address;
                        a_ready_q  <= 1'b0;
                        state_q    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (req_deny) begin
                        d_opcode_q  <= deny_opcode(req_op_q);
                        d_denied_q  <= 1'b1;
                        d_corrupt_q <= 1'b0;
                        d_data_q    <= '0;
                        d_valid_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (line_hit) begin
                        d_opcode_q  <= ACCESS_ACK_DATA;
                        d_denied_q  <= 1'b0;
                        d_corrupt_q <= 1'b0;
                        d_data_q    <= line_word;
                        d_valid_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        mem_a_valid_q <= 1'b1;
                        state_q       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_a_fire) begin
                        mem_a_valid_q <= 1'b0;
                        mem_d_ready_q <= 1'b1;
                        beat_q        <= '0;
                        err_q         <= 1'b0;
                        flush_seen_q  <= 1'b0;
                        state_q       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (flush_i) begin
                        flush_seen_q <= 1'b1;
                    end
                    if (mem_d_fire) begin
                        beat_q <= beat_q + 1'b1;
                        err_q  <= fill_err_d;
                        if (beat_q == req_word) begin
                            d_data_q <= mem_d_data;
                        end
                        if (last_beat) begin
                            mem_d_ready_q <= 1'b0;
                            d_opcode_q    <= ACCESS_ACK_DATA;
                            d_denied_q    <= fill_err_d;
                            d_corrupt_q   <= fill_err_d;
                            d_valid_q     <= 1'b1;
                            state_q       <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (d_fire) begin
                        d_valid_q <= 1'b0;
                        a_ready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_a_ready   = a_ready_q;
    assign cpu_d_opcode  = d_opcode_q;
    assign cpu_d_size    = req_size_q;
    assign cpu_d_source  = req_src_q;
    assign cpu_d_denied  = d_denied_q;
    assign cpu_d_data    = d_data_q;
    assign cpu_d_corrupt = d_corrupt_q;
    assign cpu_d_valid   = d_valid_q;
    assign mem_a_size    = FILL_SIZE;
    assign mem_a_source  = '0;
    assign mem_a_address = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign mem_a_valid   = mem_a_valid_q;
    assign mem_d_ready   = mem_d_ready_q;

endmodule

// File: tb/tb_flash_line_cache.sv
// Self-checking bench for flash_line_cache: directed vector table, reset
// corner cases and randomized traffic against a line-level cache model.
module tb_flash_line_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  cpu_a_opcode = '0;
    logic [3:0]  cpu_a_size = '0;
    logic [2:0]  cpu_a_source = '0;
    logic [23:0] cpu_a_address = '0;
    logic        cpu_a_valid = 1'b0;
    logic        cpu_a_ready;
    logic [2:0]  cpu_d_opcode;
    logic [3:0]  cpu_d_size;
    logic [2:0]  cpu_d_source;
    logic        cpu_d_denied;
    logic [31:0] cpu_d_data;
    logic        cpu_d_corrupt;
    logic        cpu_d_valid;
    logic        cpu_d_ready = 1'b0;
    logic [3:0]  mem_a_size;
    logic [2:0]  mem_a_source;
    logic [23:0] mem_a_address;
    logic        mem_a_valid;
    logic        mem_a_ready = 1'b0;
    logic [2:0]  mem_d_opcode = 3'd1;
    logic [3:0]  mem_d_size = 4'd4;
    logic [2:0]  mem_d_source = '0;
    logic        mem_d_denied = 1'b0;
    logic [31:0] mem_d_data = '0;
    logic        mem_d_corrupt = 1'b0;
    logic        mem_d_valid = 1'b0;
    logic        mem_d_ready;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    flash_line_cache #(.TL_RS(3), .LINES(8)) dut (
        .flash_clock_i (clk),
        .flash_reset_ni(rst_n),
        .flush_i       (flush_i),
        .cpu_a_opcode  (cpu_a_opcode),
        .cpu_a_size    (cpu_a_size),
        .cpu_a_source  (cpu_a_source),
        .cpu_a_address (cpu_a_address),
        .cpu_a_valid   (cpu_a_valid),
        .cpu_a_ready   (cpu_a_ready),
        .cpu_d_opcode  (cpu_d_opcode),
        .cpu_d_size    (cpu_d_size),
        .cpu_d_source  (cpu_d_source),
        .cpu_d_denied  (cpu_d_denied),
        .cpu_d_data    (cpu_d_data),
        .cpu_d_corrupt (cpu_d_corrupt),
        .cpu_d_valid   (cpu_d_valid),
        .cpu_d_ready   (cpu_d_ready),
        .mem_a_size    (mem_a_size),
        .mem_a_source  (mem_a_source),
        .mem_a_address (mem_a_address),
        .mem_a_valid   (mem_a_valid),
        .mem_a_ready   (mem_a_ready),
        .mem_d_opcode  (mem_d_opcode),
        .mem_d_size    (mem_d_size),
        .mem_d_source  (mem_d_source),
        .mem_d_denied  (mem_d_denied),
        .mem_d_data    (mem_d_data),
        .mem_d_corrupt (mem_d_corrupt),
        .mem_d_valid   (mem_d_valid),
        .mem_d_ready   (mem_d_ready)
    );

    // A flash beat offered while the cache is not accepting one is an integration error.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_d_valid && !mem_d_ready))
                else $error("stray mem_d beat while cache not filling");
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] idle_outputs();
        return {cpu_a_ready, cpu_d_valid, cpu_d_opcode, cpu_d_size, cpu_d_source, cpu_d_denied,
                cpu_d_corrupt, mem_a_valid, mem_d_ready, mem_a_source, mem_a_size, 8'h00,
                mem_a_address[15:0]} ^ {32'h0, cpu_d_data};
    endfunction

    // One complete CPU transaction, with the bench acting as flash controller.
    task automatic txn(input logic [2:0] op, input logic [3:0] sz, input logic [2:0] src,
                       input logic [23:0] addr, input logic [127:0] line,
                       input int cbeat, input int dbeat, input int fbeat, input int hold,
                       output bit miss, output logic [31:0] r_data, output logic [2:0] r_opc,
                       output bit r_den, output bit r_cor);
        int cyc;
        logic [39:0] snap;
        miss = 1'b0;
        @(negedge clk);
        cpu_a_opcode  = op;
        cpu_a_size    = sz;
        cpu_a_source  = src;
        cpu_a_address = addr;
        cpu_a_valid   = 1'b1;
        cyc = 0;
        while (!cpu_a_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("a_ready_seen", cpu_a_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cpu_a_valid = 1'b0;
        cyc = 1;
        while (!cpu_d_valid && !mem_a_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("req_or_resp_seen", cpu_d_valid | mem_a_valid, 1);
        if (mem_a_valid) begin
            miss = 1'b1;
            check("miss_req_cycle", cyc, 2);
            check("mem_a_fields", {mem_a_address, mem_a_size, mem_a_source},
                  {addr[23:4], 4'h0, 4'd4, 3'd0});
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("mem_a_hold", {mem_a_valid, mem_a_address}, {1'b1, addr[23:4], 4'h0});
            end
            mem_a_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_a_ready = 1'b0;
            check("mem_a_dropped", mem_a_valid, 0);
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                mem_d_valid   = 1'b1;
                mem_d_data    = line[32*k +: 32];
                mem_d_corrupt = (k == cbeat);
                mem_d_denied  = (k == dbeat);
                flush_i       = (k == fbeat);
                check("mem_d_ready", mem_d_ready, 1);
                @(posedge clk);
                @(negedge clk);
                mem_d_valid   = 1'b0;
                mem_d_corrupt = 1'b0;
                mem_d_denied  = 1'b0;
                flush_i       = 1'b0;
            end
            check("resp_after_beat3", cpu_d_valid, 1);
        end else begin
            check("fast_resp_cycle", cyc, 2);
        end
        check("d_echo", {cpu_d_size, cpu_d_source}, {sz, src});
        r_data = cpu_d_data;
        r_opc  = cpu_d_opcode;
        r_den  = cpu_d_denied;
        r_cor  = cpu_d_corrupt;
        snap   = {cpu_d_valid, cpu_d_opcode, cpu_d_denied, cpu_d_corrupt, cpu_d_data};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("d_stable", {cpu_d_valid, cpu_d_opcode, cpu_d_denied, cpu_d_corrupt, cpu_d_data}, snap);
        end
        cpu_d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_d_ready = 1'b0;
        check("d_done", {cpu_d_valid, cpu_a_ready}, 2'b01);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [3:0]   sz;
        logic [2:0]   src;
        logic [23:0]  addr;
        logic [127:0] line;
        int           cbeat;
        int           fbeat;
        int           hold;
        bit           exp_miss;
        logic [31:0]  exp_data;
        logic [2:0]   exp_opc;
        bit           exp_den;
        bit           exp_cor;
    } vec_t;

    vec_t vt[14];

    // Line-level model: valid/tag/words per index, flash content from a fixed pattern.
    bit          mv[8];
    logic [16:0] mt[8];
    logic [31:0] md[8][4];

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return {a[23:2], 10'h2A5} ^ 32'h5A00_0000;
    endfunction

    initial begin
        bit          miss;
        logic [31:0] r_data;
        logic [2:0]  r_opc;
        bit          r_den, r_cor;
        int          cyc;

        vt[0]  = '{3'd4, 4'd2, 3'd1, 24'h000104, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                   -1, -1, 0, 1'b1, 32'h22222222, 3'd1, 1'b0, 1'b0};
        vt[1]  = '{3'd4, 4'd2, 3'd2, 24'h00010C, 128'h0, -1, -1, 0, 1'b0, 32'h44444444, 3'd1, 1'b0, 1'b0};
        vt[2]  = '{3'd4, 4'd2, 3'd3, 24'h000180, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000},
                   -1, -1, 1, 1'b1, 32'hA0000000, 3'd1, 1'b0, 1'b0};
        vt[3]  = '{3'd4, 4'd2, 3'd4, 24'h000100, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555},
                   -1, -1, 0, 1'b1, 32'h55555555, 3'd1, 1'b0, 1'b0};
        vt[4]  = '{3'd0, 4'd2, 3'd5, 24'h000000, 128'h0, -1, -1, 0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0};
        vt[5]  = '{3'd4, 4'd3, 3'd6, 24'h000104, 128'h0, -1, -1, 2, 1'b0, 32'h0, 3'd1, 1'b1, 1'b0};
        vt[6]  = '{3'd1, 4'd0, 3'd7, 24'h000008, 128'h0, -1, -1, 0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0};
        vt[7]  = '{3'd4, 4'd1, 3'd0, 24'h000106, 128'h0, -1, -1, 0, 1'b0, 32'h66666666, 3'd1, 1'b0, 1'b0};
        vt[8]  = '{3'd4, 4'd2, 3'd1, 24'h000208, {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0},
                   2, -1, 0, 1'b1, 32'hD2D2D2D2, 3'd1, 1'b1, 1'b1};
        vt[9]  = '{3'd4, 4'd2, 3'd2, 24'h000208, {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0},
                   -1, -1, 0, 1'b1, 32'hE2E2E2E2, 3'd1, 1'b0, 1'b0};
        vt[10] = '{3'd4, 4'd0, 3'd3, 24'h000205, 128'h0, -1, -1, 0, 1'b0, 32'hE1E1E1E1, 3'd1, 1'b0, 1'b0};
        vt[11] = '{3'd4, 4'd0, 3'd4, 24'h000010, {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0},
                   -1, 1, 5, 1'b1, 32'hF0F0F0F0, 3'd1, 1'b0, 1'b0};
        vt[12] = '{3'd4, 4'd2, 3'd5, 24'h00020C, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0},
                   -1, -1, 0, 1'b1, 32'hB3B3B3B3, 3'd1, 1'b0, 1'b0};
        vt[13] = '{3'd4, 4'd2, 3'd6, 24'h000014, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0},
                   -1, -1, 0, 1'b1, 32'hC1C1C1C1, 3'd1, 1'b0, 1'b0};

        #12;
        check("reset_outputs", idle_outputs(), {2'b00, 3'd0, 4'd0, 3'd0, 2'b00, 2'b00, 3'd0, 4'd4, 8'h00, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            txn(vt[i].op, vt[i].sz, vt[i].src, vt[i].addr, vt[i].line, vt[i].cbeat, -1,
                vt[i].fbeat, vt[i].hold, miss, r_data, r_opc, r_den, r_cor);
            check($sformatf("vec%0d_miss", i), miss, vt[i].exp_miss);
            check($sformatf("vec%0d_resp", i), {r_data, r_opc, r_den, r_cor},
                  {vt[i].exp_data, vt[i].exp_opc, vt[i].exp_den, vt[i].exp_cor});
        end

        // Reset in the middle of a fill: outputs clear at once, cache comes back empty.
        @(negedge clk);
        cpu_a_opcode = 3'd4; cpu_a_size = 4'd2; cpu_a_source = 3'd2;
        cpu_a_address = 24'h000300; cpu_a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_a_valid = 1'b0;
        cyc = 0;
        while (!mem_a_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("midfill_req", mem_a_valid, 1);
        mem_a_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_a_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_d_valid = 1'b1;
            mem_d_data  = 32'h77000000 + k;
            @(posedge clk);
            @(negedge clk);
        end
        check("midfill_in_fill", mem_d_ready, 1);
        mem_d_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midfill_reset_outputs", idle_outputs(),
              {2'b00, 3'd0, 4'd0, 3'd0, 2'b00, 2'b00, 3'd0, 4'd4, 8'h00, 16'h0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn(3'd4, 4'd2, 3'd1, 24'h00020C, {32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090},
            -1, -1, -1, 0, miss, r_data, r_opc, r_den, r_cor);
        check("post_reset_miss", miss, 1);
        check("post_reset_data", r_data, 32'h93939393);

        // Randomized traffic: start from a known-empty cache.
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        for (int l = 0; l < 8; l++) mv[l] = 1'b0;

        for (int n = 0; n < 200; n++) begin
            logic [2:0]   op;
            logic [3:0]   sz;
            logic [23:0]  addr;
            logic [16:0]  tag;
            logic [2:0]   idx;
            logic [127:0] line;
            int           cbeat, dbeat, fbeat;
            bit           deny, hit, err;
            logic [31:0]  e_data;
            logic [2:0]   e_opc;
            bit           e_den, e_cor;

            op   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            sz   = ($urandom_range(0, 5) == 0) ? 4'd3 : 4'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: tag = 17'd0;
                1: tag = 17'd1;
                2: tag = 17'd2;
                default: tag = 17'h1FFFF;
            endcase
            idx  = 3'($urandom_range(0, 7));
            addr = {tag, idx, 4'($urandom_range(0, 15))};
            for (int k = 0; k < 4; k++) line[32*k +: 32] = flash_word({addr[23:4], 4'(4 * k)});
            cbeat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            dbeat = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 3) : -1;
            fbeat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;

            deny = (op != 3'd4) || (sz > 4'd2);
            hit  = !deny && mv[idx] && (mt[idx] == tag);
            err  = (cbeat >= 0) || (dbeat >= 0);
            if (deny) begin
                e_data = 32'h0;
                e_opc  = (op == 3'd0 || op == 3'd1) ? 3'd0 : 3'd1;
                e_den  = 1'b1;
                e_cor  = 1'b0;
            end else if (hit) begin
                e_data = md[idx][addr[3:2]];
                e_opc  = 3'd1;
                e_den  = 1'b0;
                e_cor  = 1'b0;
            end else begin
                e_data = line[32*addr[3:2] +: 32];
                e_opc  = 3'd1;
                e_den  = err;
                e_cor  = err;
            end

            txn(op, sz, 3'($urandom_range(0, 7)), addr, line, cbeat, dbeat, fbeat,
                $urandom_range(0, 3), miss, r_data, r_opc, r_den, r_cor);
            check("rand_miss", miss, !deny && !hit);
            check("rand_resp", {r_data, r_opc, r_den, r_cor}, {e_data, e_opc, e_den, e_cor});

            if (!deny && !hit) begin
                for (int k = 0; k < 4; k++) md[idx][k] = line[32*k +: 32];
                mt[idx] = tag;
                mv[idx] = !err;
                if (fbeat >= 0) begin
                    for (int l = 0; l < 8; l++) mv[l] = 1'b0;
                end
            end
            if ($urandom_range(0, 14) == 0) begin
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
                for (int l = 0; l < 8; l++) mv[l] = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
